md_phase_sequencer: RTL and testbench

- Generalised timestep controller for the MD accelerator. It sequences NUM_PHASES compute phases per timestep across NUM_UNITS parallel compute units.
- It latches per-unit done pulses, toggles the position/velocity double buffer once per timestep, counts timesteps up to a programmed target, then reports completion.
- It sits between the memory-load logic (mem_set) and the force/update/migration pipelines.

---
 rtl/md_ctrl_pkg.sv | 14 +
 rtl/md_done_collector.sv | 21 ++
 rtl/md_phase_sequencer.sv | 100 ++++++++++
 tb/tb_md_phase_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/md_ctrl_pkg.sv
// md_ctrl_pkg: shared state encoding, phase constants and sizing helpers for the MD timestep sequencer
package md_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2, DONE = 2'd3} state_t;
  localparam int PH_FORCE = 0;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int ph_update(input int num_phases);
    return num_phases - 1;
  endfunction
endpackage

// File: rtl/md_done_collector.sv
// md_done_collector: sticky per-unit done latches; all_done also counts this cycle's pulses
module md_done_collector #(
  parameter int NUM_UNITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic                 all_done
);
  logic [NUM_UNITS-1:0] latch_q, latch_d;
  always_comb begin
    latch_d = clr ? '0 : en ? (latch_q | unit_done) : latch_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) latch_q <= '0;
    else latch_q <= latch_d;
  end
  assign all_done = &(latch_q | unit_done);
endmodule

// File: rtl/md_phase_sequencer.sv
// md_phase_sequencer: steps NUM_PHASES compute phases per timestep across NUM_UNITS units,
// flips the position/velocity buffer per timestep and stops after the programmed step count.
module md_phase_sequencer
  import md_ctrl_pkg::*;
#(
  parameter int NUM_PHASES = 2,
  parameter int NUM_UNITS  = 4,
  parameter int STEP_W     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mem_set,
  input  logic                          abort,
  input  logic [STEP_W-1:0]             num_steps,
  input  logic [NUM_UNITS-1:0]          unit_done,
  output logic [NUM_PHASES-1:0]         phase_ready,
  output logic [clog2(NUM_PHASES)-1:0]  phase_idx,
  output logic                          double_buffer,
  output logic [STEP_W-1:0]             step_count,
  output logic                          busy,
  output logic                          sim_done
);
  localparam int PW = clog2(NUM_PHASES);
  localparam logic [PW-1:0] LAST = PW'(ph_update(NUM_PHASES));
  state_t state_q, state_d;
  logic [PW-1:0] idx_q, idx_d;
  logic db_q, db_d;
  logic [STEP_W-1:0] step_q, step_d, tgt_q, tgt_d;
  logic all_done, clr, en;
  md_done_collector #(.NUM_UNITS(NUM_UNITS)) u_done (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clr      (clr),
    .unit_done(unit_done),
    .all_done (all_done)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    db_d    = db_q;
    step_d  = step_q;
    tgt_d   = tgt_q;
    en      = state_q == RUN;
    clr     = 1'b0;
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
      db_d    = 1'b0;
      step_d  = '0;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (mem_set) begin
          tgt_d   = num_steps;
          idx_d   = PW'(PH_FORCE);
          state_d = num_steps == '0 ? DONE : RUN;
        end
        RUN: if (mem_set && all_done) begin
          state_d = GAP;
          clr     = 1'b1;
        end
        // the GAP cycle never samples unit_done, so held dones cannot skip a phase
        GAP: if (mem_set) begin
          if (idx_q != LAST) begin
            idx_d   = idx_q + PW'(1);
            state_d = RUN;
          end else begin
            idx_d   = '0;
            db_d    = ~db_q;
            step_d  = step_q + STEP_W'(1);
            state_d = (step_q + STEP_W'(1)) == tgt_q ? DONE : RUN;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      db_q    <= 1'b0;
      step_q  <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      db_q    <= db_d;
      step_q  <= step_d;
      tgt_q   <= tgt_d;
    end
  end
  assign phase_ready   = state_q == RUN ? (NUM_PHASES'(1) << idx_q) : '0;
  assign phase_idx     = idx_q;
  assign double_buffer = db_q;
  assign step_count    = step_q;
  assign busy          = state_q == RUN || state_q == GAP;
  assign sim_done      = state_q == DONE;
endmodule

// File: tb/tb_md_phase_sequencer.sv
// tb_md_phase_sequencer: directed scenarios plus random traffic checked every cycle against a
// phase-count model (completed phases -> step, index, buffer) of the timestep sequencer.
module tb_md_phase_sequencer;
  localparam int NP = 2;
  localparam int NU = 4;
  localparam int SW = 32;
  localparam int PW = md_ctrl_pkg::clog2(NP);
  logic clk = 1'b0;
  logic reset, mem_set, abort;
  logic [SW-1:0] num_steps;
  logic [NU-1:0] unit_done;
  logic [NP-1:0] phase_ready;
  logic [PW-1:0] phase_idx;
  logic double_buffer, busy, sim_done;
  logic [SW-1:0] step_count;
  int vectors = 0;
  int errs = 0;
  bit m_started, m_gap;
  longint m_tgt;
  int m_comp;
  logic [NU-1:0] m_seen;
  localparam logic [NU-1:0] ALL = '1;
  md_phase_sequencer #(.NUM_PHASES(NP), .NUM_UNITS(NU), .STEP_W(SW)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_set      (mem_set),
    .abort        (abort),
    .num_steps    (num_steps),
    .unit_done    (unit_done),
    .phase_ready  (phase_ready),
    .phase_idx    (phase_idx),
    .double_buffer(double_buffer),
    .step_count   (step_count),
    .busy         (busy),
    .sim_done     (sim_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit m_running();
    return m_started && longint'(m_comp) != m_tgt * NP;
  endfunction
  function automatic logic [NP-1:0] exp_pr();
    return (m_running() && !m_gap) ? NP'(1) << (m_comp % NP) : '0;
  endfunction
  task automatic model_reset();
    m_started = 0; m_gap = 0; m_comp = 0; m_tgt = 0; m_seen = '0;
  endtask
  task automatic model_edge();
    logic [NU-1:0] acc;
    if (abort) begin
      m_started = 0; m_gap = 0; m_comp = 0; m_seen = '0;
    end else if (!m_started) begin
      if (mem_set) begin
        m_started = 1; m_tgt = longint'(num_steps); m_comp = 0; m_gap = 0; m_seen = '0;
      end
    end else if (m_running()) begin
      if (m_gap) begin
        if (mem_set) begin m_gap = 0; m_comp++; end
      end else begin
        acc = m_seen | unit_done;
        if (mem_set && &acc) begin m_gap = 1; m_seen = '0; end
        else m_seen = acc;
      end
    end
  endtask
  task automatic check_all();
    chk("phase_ready", 64'(phase_ready), 64'(exp_pr()));
    chk("phase_idx", 64'(phase_idx), 64'(m_comp % NP));
    chk("step_count", 64'(step_count), 64'(m_comp / NP));
    chk("double_buffer", 64'(double_buffer), 64'((m_comp / NP) % 2));
    chk("busy", 64'(busy), 64'(m_running()));
    chk("sim_done", 64'(sim_done), 64'(m_started && !m_running()));
  endtask
  task automatic cyc(input logic ms, input logic ab, input logic [NU-1:0] ud);
    mem_set = ms; abort = ab; unit_done = ud;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask
  task automatic do_reset();
    mem_set = 0; abort = 0; unit_done = '0; reset = 1;
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    reset = 0;
  endtask
  initial begin
    int n, age, rises, seen_pr;
    logic [NP-1:0] prev;
    reset = 1; mem_set = 0; abort = 0; unit_done = '0; num_steps = '0;
    model_reset();
    // basic run: all units pulse a few cycles into each phase
    do_reset();
    num_steps = 3;
    cyc(1, 0, '0);
    age = 0; rises = 1; prev = phase_ready;
    for (n = 0; n < 200 && m_running(); n++) begin
      age = exp_pr() != '0 ? age + 1 : 0;
      cyc(1, 0, age == 3 ? ALL : '0);
      if (phase_ready != '0 && prev == '0) rises++;
      prev = phase_ready;
    end
    chk("basic_rises", 64'(rises), 64'(3 * NP));
    chk("basic_db", 64'(double_buffer), 64'(1));
    chk("basic_steps", 64'(step_count), 64'(3));
    chk("basic_done", 64'(sim_done), 64'(1));
    // staggered done pulses in phase 0
    do_reset();
    num_steps = 1;
    cyc(1, 0, '0);
    for (int k = 1; k <= 7; k++) begin
      cyc(1, 0, {k == 7, k == 2, k == 4, k == 1});
      if (k < 7) chk("stag_hold", 64'(phase_ready), 64'(1));
    end
    chk("stag_gap", 64'(phase_ready), 64'(0));
    cyc(1, 0, '0);
    chk("stag_ph1", 64'(phase_ready), 64'(2));
    // level-held done: 1 RUN + 1 GAP cycle per phase
    do_reset();
    num_steps = 2;
    n = 0;
    while (!sim_done && n < 50) begin
      cyc(1, 0, ALL);
      n++;
    end
    chk("level_cycles", 64'(n), 64'(9));
    // zero steps
    do_reset();
    num_steps = 0;
    seen_pr = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(1, 0, NU'($urandom));
      if (phase_ready != '0) seen_pr = 1;
    end
    chk("zero_pr", 64'(seen_pr), 64'(0));
    chk("zero_done", 64'(sim_done), 64'(1));
    chk("zero_steps", 64'(step_count), 64'(0));
    chk("zero_db", 64'(double_buffer), 64'(0));
    // pause mid phase 1, with unit 2 finishing while paused
    do_reset();
    num_steps = 2;
    cyc(1, 0, '0);
    cyc(1, 0, ALL);
    cyc(1, 0, '0);
    cyc(1, 0, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, k == 2 ? 4'b0100 : 4'b0000);
      chk("pause_pr", 64'(phase_ready), 64'(2));
      chk("pause_idx", 64'(phase_idx), 64'(1));
    end
    cyc(1, 0, 4'b1010);
    chk("pause_resume", 64'(phase_ready), 64'(0));
    cyc(1, 0, '0);
    chk("pause_step", 64'(step_count), 64'(1));
    // abort coincident with the final done of step 3 of 5
    do_reset();
    num_steps = 5;
    cyc(1, 0, '0);
    for (n = 0; n < 100 && !(m_comp == 2 * NP + NP - 1 && !m_gap); n++) cyc(1, 0, ALL);
    cyc(1, 1, ALL);
    chk("abort_steps", 64'(step_count), 64'(0));
    chk("abort_db", 64'(double_buffer), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    cyc(0, 0, '0);
    chk("abort_idle", 64'(phase_ready), 64'(0));
    // asynchronous reset in the middle of a GAP cycle
    do_reset();
    num_steps = 4;
    cyc(1, 0, '0);
    for (n = 0; n < 100 && !(m_gap && m_comp == NP + 1); n++) cyc(1, 0, ALL);
    chk("ar_pre_db", 64'(double_buffer), 64'(1));
    #2 reset = 1;
    #1;
    model_reset();
    chk("ar_step", 64'(step_count), 64'(0));
    chk("ar_db", 64'(double_buffer), 64'(0));
    chk("ar_idx", 64'(phase_idx), 64'(0));
    chk("ar_busy", 64'(busy), 64'(0));
    check_all();
    @(negedge clk);
    reset = 0;
    // random traffic
    for (int r = 0; r < 8; r++) begin
      bit level;
      do_reset();
      level = $urandom_range(0, 3) == 0;
      num_steps = SW'($urandom_range(0, 3));
      for (int k = 0; k < 250; k++) begin
        if ($urandom_range(0, 30) == 0) num_steps = SW'($urandom_range(0, 3));
        cyc($urandom_range(0, 9) != 0, $urandom_range(0, 150) == 0,
            level ? ALL : NU'($urandom & $urandom));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
